// File: rtl/start_banner_rect.sv
// Start-screen banner rectangle: slides up from below the screen, holds, then blinks.
// Outputs a registered inside flag and bitmap offsets one cycle after the scan pixel.
module start_banner_rect #(
  parameter int OBJECT_WIDTH_X = 64,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int X_POS = 288,
  parameter int INIT_Y = 480,
  parameter int TARGET_Y = 200,
  parameter int SPEED = 4,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        enable,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic [10:0] topLeftY,
  output logic        settled
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SLIDE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [10:0] INIT_Y11   = 11'(INIT_Y);
  localparam logic [10:0] TARGET_Y11 = 11'(TARGET_Y);
  localparam logic [11:0] TARGET_Y12 = 12'(TARGET_Y);
  localparam logic [11:0] SPEED12    = 12'(SPEED);
  localparam logic [11:0] X_LO12     = 12'(X_POS);
  localparam logic [11:0] X_HI12     = 12'(X_POS + OBJECT_WIDTH_X);
  localparam logic [11:0] HEIGHT12   = 12'(OBJECT_HEIGHT_Y);

  logic [1:0]    state_q, state_d;
  logic [10:0]   top_y_q, top_y_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          visible_q, visible_d;
  logic          inside_q, inside_d;
  logic [10:0]   offset_x_q, offset_x_d;
  logic [10:0]   offset_y_q, offset_y_d;
  logic          settled_q, settled_d;

  logic [11:0] px12_s, py12_s, ty12_s, step12_s;
  logic        hit_s;

  // Banner motion and blink sequencing; dropping enable wins over everything.
  always_comb begin
    state_d   = state_q;
    top_y_d   = top_y_q;
    cnt_d     = cnt_q;
    visible_d = visible_q;
    step12_s  = {1'b0, top_y_q} - SPEED12;
    if (!enable) begin
      state_d   = IDLE;
      top_y_d   = INIT_Y11;
      cnt_d     = CNT_ZERO;
      visible_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = SLIDE;
          top_y_d   = INIT_Y11;
          cnt_d     = CNT_ZERO;
          visible_d = 1'b1;
        end
        SLIDE: begin
          visible_d = 1'b1;
          if (startOfFrame) begin
            // Compare before subtracting so a step past the target clamps cleanly.
            if ({1'b0, top_y_q} <= (TARGET_Y12 + SPEED12)) begin
              top_y_d = TARGET_Y11;
              state_d = HOLD;
            end else begin
              top_y_d = step12_s[10:0];
            end
          end else begin
            top_y_d = top_y_q;
          end
        end
        HOLD: begin
          top_y_d = TARGET_Y11;
          if (startOfFrame) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d     = CNT_ZERO;
              visible_d = ~visible_q;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d   = IDLE;
          top_y_d   = INIT_Y11;
          cnt_d     = CNT_ZERO;
          visible_d = 1'b1;
        end
      endcase
    end
    settled_d = (state_d == HOLD);
  end

  // Pixel hit test against the current registered banner position.
  always_comb begin
    px12_s = {1'b0, pixelX};
    py12_s = {1'b0, pixelY};
    ty12_s = {1'b0, top_y_q};
    hit_s  = (px12_s >= X_LO12) && (px12_s < X_HI12) &&
             (py12_s >= ty12_s) && (py12_s < (ty12_s + HEIGHT12)) &&
             (state_q != IDLE) && visible_q;
    if (hit_s) begin
      inside_d   = 1'b1;
      offset_x_d = pixelX - X_LO12[10:0];
      offset_y_d = pixelY - top_y_q;
    end else begin
      inside_d   = 1'b0;
      offset_x_d = 11'd0;
      offset_y_d = 11'd0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      top_y_q    <= INIT_Y11;
      cnt_q      <= CNT_ZERO;
      visible_q  <= 1'b1;
      inside_q   <= 1'b0;
      offset_x_q <= 11'd0;
      offset_y_q <= 11'd0;
      settled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      top_y_q    <= top_y_d;
      cnt_q      <= cnt_d;
      visible_q  <= visible_d;
      inside_q   <= inside_d;
      offset_x_q <= offset_x_d;
      offset_y_q <= offset_y_d;
      settled_q  <= settled_d;
    end
  end

  assign InsideRectangle = inside_q;
  assign offsetX         = offset_x_q;
  assign offsetY         = offset_y_q;
  assign topLeftY        = top_y_q;
  assign settled         = settled_q;

endmodule

// File: tb/tb_start_banner_rect.sv
// Scoreboard bench for start_banner_rect: default instance plus a SPEED=7 instance on shared inputs.
module tb_start_banner_rect;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN;
  logic [10:0] pixelX, pixelY;
  logic        startOfFrame, enable;

  logic        ins4, set4, ins7, set7;
  logic [10:0] ox4, oy4, ty4, ox7, oy7, ty7;

  start_banner_rect u4 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .enable(enable),
    .InsideRectangle(ins4), .offsetX(ox4), .offsetY(oy4),
    .topLeftY(ty4), .settled(set4)
  );

  start_banner_rect #(.SPEED(7)) u7 (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .enable(enable),
    .InsideRectangle(ins7), .offsetX(ox7), .offsetY(oy7),
    .topLeftY(ty7), .settled(set7)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    int          tag;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
  } exp_t;

  exp_t sb_q[$];
  logic probe = 1'b0;
  logic probe_q = 1'b0;

  always @(posedge clk) probe_q <= probe;

  // Monitor: a probed pixel's response is visible at the following negedge.
  always @(negedge clk) begin
    exp_t e;
    if (probe_q) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_underflow: response with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        if ({ins4, ox4, oy4} !== {e.ins, e.ox, e.oy}) begin
          n_bad++;
          $display("FAIL pix%0d got ins=%0b off=(%0d,%0d) want ins=%0b off=(%0d,%0d)",
                   e.tag, ins4, ox4, oy4, e.ins, e.ox, e.oy);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic cyc(input logic [10:0] px, input logic [10:0] py, input logic s,
                     input logic e, input logic pr, input logic ei,
                     input logic [10:0] eox, input logic [10:0] eoy, input int tag);
    exp_t x;
    pixelX = px; pixelY = py; startOfFrame = s; enable = e; probe = pr;
    if (pr) begin
      x.tag = tag; x.ins = ei; x.ox = eox; x.oy = eoy;
      sb_q.push_back(x);
    end
    @(negedge clk);
  endtask

  task automatic idle_cyc(input logic s, input logic e);
    cyc(11'd0, 11'd0, s, e, 1'b0, 1'b0, 11'd0, 11'd0, 0);
  endtask

  task automatic pix(input int px, input int py, input logic e, input logic ei,
                     input int eox, input int eoy, input int tag);
    cyc(11'(px), 11'(py), 1'b0, e, 1'b1, ei, 11'(eox), 11'(eoy), tag);
  endtask

  function automatic int slide_y(input int k, input int spd);
    int y;
    y = 480 - spd * k;
    return (y < 200) ? 200 : y;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit vis;
    resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0;
    pixelX = 11'd0; pixelY = 11'd0;
    repeat (3) @(negedge clk);
    chk("rst_top", ty4, 480);
    chk("rst_settled", set4, 0);
    chk("rst_inside", ins4, 0);
    chk("rst_offx", ox4, 0);
    chk("rst_offy", oy4, 0);
    chk("rst_top7", ty7, 480);
    resetN = 1'b1;
    @(negedge clk);

    // Idle: banner hidden even where its rectangle would be.
    pix(288, 480, 1'b0, 1'b0, 0, 0, 1);
    pix(300, 490, 1'b0, 1'b0, 0, 0, 2);
    pix(351, 511, 1'b0, 1'b0, 0, 0, 3);
    pix(0, 0, 1'b0, 1'b0, 0, 0, 4);
    idle_cyc(1'b1, 1'b0);
    chk("idle_top", ty4, 480);
    chk("idle_settled", set4, 0);

    // Enter SLIDE with a simultaneous frame strobe: no motion.
    idle_cyc(1'b1, 1'b1);
    chk("enter_top", ty4, 480);
    chk("enter_settled", set4, 0);

    for (int k = 1; k <= 70; k++) begin
      idle_cyc(1'b1, 1'b1);
      chk($sformatf("top4_k%0d", k), ty4, slide_y(k, 4));
      chk($sformatf("set4_k%0d", k), set4, (k >= 70) ? 1 : 0);
      chk($sformatf("top7_k%0d", k), ty7, slide_y(k, 7));
      chk($sformatf("set7_k%0d", k), set7, (k >= 40) ? 1 : 0);
      idle_cyc(1'b0, 1'b1);
      if (k == 10) begin
        pix(288, 440, 1'b1, 1'b1, 0, 0, 10);
        pix(300, 471, 1'b1, 1'b1, 12, 31, 11);
        pix(300, 472, 1'b1, 1'b0, 0, 0, 12);
        pix(300, 439, 1'b1, 1'b0, 0, 0, 13);
      end
    end

    // Hit test at the settled position.
    pix(288, 200, 1'b1, 1'b1, 0, 0, 20);
    pix(351, 231, 1'b1, 1'b1, 63, 31, 21);
    pix(352, 200, 1'b1, 1'b0, 0, 0, 22);
    pix(288, 232, 1'b1, 1'b0, 0, 0, 23);
    pix(287, 200, 1'b1, 1'b0, 0, 0, 24);
    pix(288, 199, 1'b1, 1'b0, 0, 0, 25);

    // Blink: 30 frames on, 30 off, then on again.
    for (int f = 0; f < 65; f++) begin
      vis = ((f / 30) % 2) == 0;
      pix(300, 210, 1'b1, vis, vis ? 12 : 0, vis ? 10 : 0, 100 + f);
      idle_cyc(1'b1, 1'b1);
    end
    chk("hold_top", ty4, 200);
    chk("hold_settled", set4, 1);

    // Abort mid-slide at frame 20 together with a frame strobe.
    idle_cyc(1'b0, 1'b0);
    chk("abort0_top", ty4, 480);
    chk("abort0_settled", set4, 0);
    idle_cyc(1'b0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      idle_cyc(1'b1, 1'b1);
      idle_cyc(1'b0, 1'b1);
    end
    chk("f20_top", ty4, 400);
    chk("f20_top7", ty7, 340);
    idle_cyc(1'b1, 1'b0);
    chk("abort_top", ty4, 480);
    chk("abort_settled", set4, 0);
    chk("abort_top7", ty7, 480);
    pix(288, 400, 1'b0, 1'b0, 0, 0, 30);
    pix(288, 480, 1'b0, 1'b0, 0, 0, 31);
    idle_cyc(1'b0, 1'b1);
    chk("reen_top", ty4, 480);
    idle_cyc(1'b1, 1'b1);
    chk("reen_step_top", ty4, 476);
    chk("reen_step_top7", ty7, 473);

    // Asynchronous reset while a hit is being presented.
    pix(288, 476, 1'b1, 1'b1, 0, 0, 40);
    #2;
    probe = 1'b0;
    resetN = 1'b0;
    #1;
    chk("arst_inside", ins4, 0);
    chk("arst_top", ty4, 480);
    chk("arst_top7", ty7, 480);
    chk("arst_settled", set4, 0);
    chk("arst_offx", ox4, 0);
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
